// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving NUM_CORES cores fixed-latency access
// to a single registered-output RAM, one transaction every four cycles.
module mem_arbiter #(
   parameter int NUM_CORES  = 4,
   parameter int WIDTH      = 12,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                            clk,
   input  logic                            rstN,
   input  logic [NUM_CORES-1:0]            req,
   input  logic [NUM_CORES-1:0]            wrEn_core,
   input  logic [NUM_CORES*ADDR_WIDTH-1:0] addr_core,
   input  logic [NUM_CORES*WIDTH-1:0]      dataIn_core,
   output logic [NUM_CORES-1:0]            ack,
   output logic [WIDTH-1:0]                rdData,
   output logic                            busy,
   output logic                            mem_wrEn,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   output logic [WIDTH-1:0]                mem_dataIn,
   input  logic [WIDTH-1:0]                mem_dataOut
);
   localparam int GW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
   state_t                 state_q;
   logic [NUM_CORES-1:0]   ack_q;
   logic [WIDTH-1:0]       rd_q;
   logic                   busy_q;
   logic                   mem_wr_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [WIDTH-1:0]       data_q;
   logic                   wr_q;
   logic [GW-1:0]          grant_q;
   logic [GW-1:0]          last_q;
   logic [GW-1:0]          win_d;
   logic [GW-1:0]          idx;
   logic                   found;
   logic [ADDR_WIDTH-1:0]  addr_d;
   logic [WIDTH-1:0]       data_d;
   logic                   wr_d;
   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      win_d  = grant_q;
      idx    = '0;
      found  = 1'b0;
      addr_d = '0;
      data_d = '0;
      wr_d   = 1'b0;
      for (int k = 1; k <= NUM_CORES; k++) begin
         idx = GW'((int'(last_q) + k) % NUM_CORES);
         if (!found && req[idx]) begin
            found = 1'b1;
            win_d = idx;
         end
      end
      for (int i = 0; i < NUM_CORES; i++) begin
         if (win_d == GW'(i)) begin
            addr_d = addr_core[i*ADDR_WIDTH +: ADDR_WIDTH];
            data_d = dataIn_core[i*WIDTH +: WIDTH];
            wr_d   = wrEn_core[i];
         end
      end
   end
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q  <= IDLE;
         ack_q    <= '0;
         rd_q     <= '0;
         busy_q   <= 1'b0;
         mem_wr_q <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         wr_q     <= 1'b0;
         grant_q  <= '0;
         last_q   <= GW'(NUM_CORES - 1);
      end else begin
         ack_q    <= '0;
         mem_wr_q <= 1'b0;
         case (state_q)
            IDLE: if (|req) begin
               state_q  <= ACCESS;
               busy_q   <= 1'b1;
               grant_q  <= win_d;
               last_q   <= win_d;
               addr_q   <= addr_d;
               data_q   <= data_d;
               wr_q     <= wr_d;
               mem_wr_q <= wr_d;
            end
            ACCESS: state_q <= WAIT;
            // RAM output reflects the ACCESS-cycle address by now.
            WAIT: begin
               state_q        <= RESP;
               ack_q[grant_q] <= 1'b1;
               if (!wr_q) rd_q <= mem_dataOut;
            end
            RESP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign ack        = ack_q;
   assign rdData     = rd_q;
   assign busy       = busy_q;
   assign mem_wrEn   = mem_wr_q;
   assign mem_addr   = addr_q;
   assign mem_dataIn = data_q;
endmodule
